voice_scheduler: RTL and testbench

//  Polyphonic controller in front of a bank of Note voices. Maps NUM_KEYS key lines onto
//  NUM_VOICES Note instances: allocates a free voice per key-on, steals the oldest voice

---
 rtl/synth_pkg.sv | 21 ++
 rtl/wt_recorder.sv | 92 +++++++++
 rtl/voice_scheduler.sv | 132 +++++++++++++
 tb/tb_voice_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants, recorder state encoding and a width helper for the voice scheduler slice.
package synth_pkg;

  localparam int WT_WIDTH = 32;
  localparam int TSEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOADED = 2'd2
  } rec_state_t;

  // Ceiling log2 with a floor of 1 so single-entry fields still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/wt_recorder.sv
// Serial wavetable capture: shifts MSB-first bits into a shadow register and publishes
// only complete tables on rec_wt, holding record high while a loaded table is valid.
module wt_recorder #(
  parameter int WIDTH = synth_pkg::WT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             rec_start,
  input  logic             rec_valid,
  input  logic             rec_bit,
  input  logic             rec_clear,
  output logic [WIDTH-1:0] rec_wt,
  output logic             record,
  output logic             rec_busy
);
  import synth_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  rec_state_t       state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] wt_q, wt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             record_q, record_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    wt_d     = wt_q;
    count_d  = count_q;
    record_d = record_q;
    busy_d   = busy_q;
    // A start always wins; a previously loaded table keeps sounding until replaced.
    if (rec_start) begin
      state_d = SHIFT;
      count_d = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (rec_clear) begin
            state_d  = IDLE;
            count_d  = '0;
            busy_d   = 1'b0;
            record_d = 1'b0;
          end else if (rec_valid) begin
            shadow_d = {shadow_q[WIDTH-2:0], rec_bit};
            count_d  = count_q + 1'b1;
            if (count_q == CNT_W'(WIDTH - 1)) begin
              wt_d     = shadow_d;
              record_d = 1'b1;
              busy_d   = 1'b0;
              count_d  = '0;
              state_d  = LOADED;
            end
          end
        end
        LOADED: begin
          if (rec_clear) begin
            state_d  = IDLE;
            record_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      wt_q     <= '0;
      count_q  <= '0;
      record_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      wt_q     <= wt_d;
      count_q  <= count_d;
      record_q <= record_d;
      busy_q   <= busy_d;
    end
  end

  assign rec_wt   = wt_q;
  assign record   = record_q;
  assign rec_busy = busy_q;

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic key-to-voice allocator with oldest-voice stealing, per-voice table latching,
// and the shared wavetable recorder feeding every Note's Record/Rec_WT pair.
module voice_scheduler #(
  parameter int NUM_KEYS   = 8,
  parameter int NUM_VOICES = 4,
  parameter int WT_WIDTH   = synth_pkg::WT_WIDTH,
  localparam int KEY_W     = synth_pkg::clog2(NUM_KEYS),
  localparam int TSEL_W    = synth_pkg::TSEL_W
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_KEYS-1:0]         Keys,
  input  logic [TSEL_W-1:0]           TableSel,
  input  logic                        Rec_Start,
  input  logic                        Rec_Valid,
  input  logic                        Rec_Bit,
  input  logic                        Rec_Clear,
  output logic [NUM_VOICES-1:0]       Voice_Press,
  output logic [NUM_VOICES*KEY_W-1:0] Voice_Key,
  output logic [NUM_VOICES*TSEL_W-1:0] Voice_Table,
  output logic                        Record,
  output logic [WT_WIDTH-1:0]         Rec_WT,
  output logic                        Rec_Busy
);
  import synth_pkg::*;

  localparam int VID_W = clog2(NUM_VOICES);

  logic [NUM_KEYS-1:0]   keys_q, pending_q, pending_d, fall_q;
  logic [NUM_KEYS-1:0]   rise, fall;
  logic [NUM_VOICES-1:0] press_q, press_d, gap_q, gap_d;
  logic [KEY_W-1:0]      vkey_q [NUM_VOICES];
  logic [KEY_W-1:0]      vkey_d [NUM_VOICES];
  logic [TSEL_W-1:0]     vtab_q [NUM_VOICES];
  logic [TSEL_W-1:0]     vtab_d [NUM_VOICES];
  logic [VID_W-1:0]      rank_q [NUM_VOICES];
  logic [VID_W-1:0]      rank_d [NUM_VOICES];

  logic             key_found, free_found;
  logic [KEY_W-1:0] key_idx;
  logic [VID_W-1:0] free_idx, steal_idx, alloc_idx;

  always_comb begin
    rise      = Keys & ~keys_q;
    fall      = ~Keys & keys_q;
    pending_d = (pending_q | rise) & Keys;
    press_d   = press_q | gap_q;
    gap_d     = '0;
    vkey_d    = vkey_q;
    vtab_d    = vtab_q;
    rank_d    = rank_q;

    // Release covers voices still inside their retrigger gap, so a short press never sticks.
    for (int v = 0; v < NUM_VOICES; v++)
      if (press_d[v] && fall_q[vkey_q[v]]) press_d[v] = 1'b0;

    key_found = 1'b0;
    key_idx   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (pending_q[k]) begin
        key_found = 1'b1;
        key_idx   = KEY_W'(k);
      end

    free_found = 1'b0;
    free_idx   = '0;
    steal_idx  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!press_d[v]) begin
        free_found = 1'b1;
        free_idx   = VID_W'(v);
      end
      if (rank_q[v] == VID_W'(NUM_VOICES - 1)) steal_idx = VID_W'(v);
    end
    alloc_idx = free_found ? free_idx : steal_idx;

    if (key_found) begin
      pending_d[key_idx] = 1'b0;
      vkey_d[alloc_idx]  = key_idx;
      vtab_d[alloc_idx]  = TableSel;
      press_d[alloc_idx] = free_found;
      gap_d[alloc_idx]   = ~free_found;
      for (int v = 0; v < NUM_VOICES; v++)
        if (rank_q[v] < rank_q[alloc_idx]) rank_d[v] = rank_q[v] + 1'b1;
      rank_d[alloc_idx] = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      keys_q    <= '0;
      pending_q <= '0;
      fall_q    <= '0;
      press_q   <= '0;
      gap_q     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey_q[v] <= '0;
        vtab_q[v] <= '0;
        rank_q[v] <= VID_W'(v);
      end
    end else begin
      keys_q    <= Keys;
      pending_q <= pending_d;
      fall_q    <= fall;
      press_q   <= press_d;
      gap_q     <= gap_d;
      vkey_q    <= vkey_d;
      vtab_q    <= vtab_d;
      rank_q    <= rank_d;
    end
  end

  assign Voice_Press = press_q;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
    assign Voice_Key[gi*KEY_W +: KEY_W]     = vkey_q[gi];
    assign Voice_Table[gi*TSEL_W +: TSEL_W] = vtab_q[gi];
  end

  wt_recorder #(.WIDTH(WT_WIDTH)) u_rec (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .rec_start (Rec_Start),
    .rec_valid (Rec_Valid),
    .rec_bit   (Rec_Bit),
    .rec_clear (Rec_Clear),
    .rec_wt    (Rec_WT),
    .record    (Record),
    .rec_busy  (Rec_Busy)
  );

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, stealing, release, table latching and capture.
module tb_voice_scheduler;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  Keys;
  logic [2:0]  TableSel;
  logic        Rec_Start, Rec_Valid, Rec_Bit, Rec_Clear;
  logic [3:0]  Voice_Press;
  logic [11:0] Voice_Key;
  logic [11:0] Voice_Table;
  logic        Record;
  logic [31:0] Rec_WT;
  logic        Rec_Busy;

  int checks   = 0;
  int failures = 0;

  voice_scheduler dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Keys        (Keys),
    .TableSel    (TableSel),
    .Rec_Start   (Rec_Start),
    .Rec_Valid   (Rec_Valid),
    .Rec_Bit     (Rec_Bit),
    .Rec_Clear   (Rec_Clear),
    .Voice_Press (Voice_Press),
    .Voice_Key   (Voice_Key),
    .Voice_Table (Voice_Table),
    .Record      (Record),
    .Rec_WT      (Rec_WT),
    .Rec_Busy    (Rec_Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge; each step crosses one rising edge.
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    Keys = '0; TableSel = '0;
    Rec_Start = 0; Rec_Valid = 0; Rec_Bit = 0; Rec_Clear = 0;
    RST_N = 1'b0;
    step(1);
    RST_N = 1'b1;
  endtask

  function automatic logic [7:0] ranks();
    return {dut.rank_q[3], dut.rank_q[2], dut.rank_q[1], dut.rank_q[0]};
  endfunction

  logic [31:0] pat;

  initial begin
    // 1: reset state
    Keys = '0; TableSel = '0;
    Rec_Start = 0; Rec_Valid = 0; Rec_Bit = 0; Rec_Clear = 0;
    RST_N = 1'b0;
    step(2);
    check("rst_press", Voice_Press, 0);
    check("rst_key",   Voice_Key, 0);
    check("rst_table", Voice_Table, 0);
    check("rst_rec",   {Record, Rec_Busy}, 0);
    check("rst_wt",    Rec_WT, 0);
    check("rst_rank",  ranks(), {2'd3, 2'd2, 2'd1, 2'd0});
    RST_N = 1'b1;
    step(1);

    // 2: single key on/off, table latched at allocation
    TableSel = 3'd3;
    Keys[5]  = 1'b1;
    step(1);
    check("t2_press_lat1", Voice_Press, 4'b0000);
    step(1);
    check("t2_press_on", Voice_Press, 4'b0001);
    check("t2_key0",     Voice_Key[2:0], 5);
    check("t2_tab0",     Voice_Table[2:0], 3);
    TableSel = 3'd6;
    Keys[5]  = 1'b0;
    step(1);
    check("t2_tab_held",  Voice_Table[2:0], 3);
    check("t2_press_hold", Voice_Press, 4'b0001);
    step(1);
    check("t2_press_off", Voice_Press, 4'b0000);

    // 3: fill all voices, then steal the oldest
    do_reset();
    for (int k = 0; k < 4; k++) begin
      Keys[k] = 1'b1;
      step(1);
    end
    step(1);
    check("t3_full_press", Voice_Press, 4'b1111);
    check("t3_full_keys",  Voice_Key, {3'd3, 3'd2, 3'd1, 3'd0});
    check("t3_full_rank",  ranks(), {2'd0, 2'd1, 2'd2, 2'd3});
    TableSel = 3'd5;
    Keys[6]  = 1'b1;
    step(2);
    check("t3_gap_press", Voice_Press, 4'b1110);
    check("t3_gap_key",   Voice_Key, {3'd3, 3'd2, 3'd1, 3'd6});
    step(1);
    check("t3_steal_press", Voice_Press, 4'b1111);
    check("t3_steal_table", Voice_Table, {3'd0, 3'd0, 3'd0, 3'd5});
    check("t3_steal_rank",  ranks(), {2'd1, 2'd2, 2'd3, 2'd0});
    step(3);
    check("t3_key0_unvoiced", Voice_Key, {3'd3, 3'd2, 3'd1, 3'd6});
    Keys[0] = 1'b0;
    step(2);
    check("t3_key0_off_noop", Voice_Press, 4'b1111);
    Keys[0] = 1'b1;
    step(2);
    check("t3_repress_gap", Voice_Press, 4'b1101);
    check("t3_repress_key", Voice_Key[5:3], 0);
    step(1);
    check("t3_repress_on", Voice_Press, 4'b1111);

    // 4: simultaneous rises with one free voice, then release+press reuse
    do_reset();
    Keys = 8'b0000_1011;
    step(4);
    check("t4_three", Voice_Press, 4'b0111);
    check("t4_three_keys", Voice_Key[8:0], {3'd3, 3'd1, 3'd0});
    Keys = Keys | 8'b0001_0100;
    step(2);
    check("t4_key2_free", Voice_Press, 4'b1111);
    check("t4_key2_v3",   Voice_Key[11:9], 2);
    step(1);
    check("t4_key4_gap", Voice_Press, 4'b1110);
    check("t4_key4_v0",  Voice_Key[2:0], 4);
    step(1);
    check("t4_key4_on", Voice_Press, 4'b1111);
    Keys[1] = 1'b0;
    Keys[7] = 1'b1;
    step(1);
    check("t4_reuse_pre", Voice_Key, {3'd2, 3'd3, 3'd1, 3'd4});
    step(1);
    check("t4_reuse_press", Voice_Press, 4'b1111);
    check("t4_reuse_keys",  Voice_Key, {3'd2, 3'd3, 3'd7, 3'd4});

    // 5: full capture with a valid gap, then clear
    do_reset();
    pat = 32'hA5A5_0F0F;
    Rec_Start = 1'b1;
    step(1);
    Rec_Start = 1'b0;
    check("t5_busy", {Rec_Busy, Record}, 2'b10);
    for (int i = 31; i >= 0; i--) begin
      if (i == 15) begin
        Rec_Valid = 1'b0;
        step(2);
      end
      Rec_Valid = 1'b1;
      Rec_Bit   = pat[i];
      if (i == 0) check("t5_pre_last", Record, 0);
      step(1);
    end
    Rec_Valid = 1'b0;
    check("t5_wt",     Rec_WT, 32'hA5A5_0F0F);
    check("t5_loaded", {Record, Rec_Busy}, 2'b10);
    Rec_Clear = 1'b1;
    step(1);
    Rec_Clear = 1'b0;
    check("t5_clear_rec", Record, 0);
    check("t5_clear_wt",  Rec_WT, 32'hA5A5_0F0F);

    // 6: restart after 10 bits, reload while loaded, async reset mid-capture
    Keys[2]   = 1'b1;
    Rec_Start = 1'b1;
    step(1);
    Rec_Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      Rec_Valid = 1'b1;
      Rec_Bit   = 1'b1;
      step(1);
    end
    Rec_Valid = 1'b0;
    Rec_Start = 1'b1;
    step(1);
    Rec_Start = 1'b0;
    pat = 32'h1234_5678;
    for (int i = 31; i >= 0; i--) begin
      Rec_Valid = 1'b1;
      Rec_Bit   = pat[i];
      if (i == 0) check("t6_restart_count", {Record, Rec_Busy}, 2'b01);
      step(1);
    end
    Rec_Valid = 1'b0;
    check("t6_wt",  Rec_WT, 32'h1234_5678);
    check("t6_rec", Record, 1);
    Rec_Start = 1'b1;
    step(1);
    Rec_Start = 1'b0;
    check("t6_reload_hold", {Record, Rec_Busy}, 2'b11);
    check("t6_reload_wt",   Rec_WT, 32'h1234_5678);
    check("t6_voice_on",    Voice_Press, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      Rec_Valid = 1'b1;
      Rec_Bit   = i[0];
      step(1);
    end
    #2 RST_N = 1'b0;
    #1;
    check("t6_arst_wt",    Rec_WT, 0);
    check("t6_arst_flags", {Record, Rec_Busy}, 0);
    check("t6_arst_press", Voice_Press, 0);
    Rec_Valid = 1'b0;
    step(1);
    RST_N = 1'b1;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
